// File: rtl/display_avg_bank.sv
// Box-car averages N channels over 2^AVG_LOG2 valid samples and publishes them to display registers.
// Latency: one clock from the window-completing sample edge to ch_display/update.
// No backpressure: every valid sample is accepted; freeze only suppresses publishing.
// Optional feature macro: PEAK_HOLD_EN (adds peak_display/peak_clear and per-channel peak registers).
module display_avg_bank #(
  parameter int N        = 5,
  parameter int W        = 12,
  parameter int AVG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [N*W-1:0]      ch_in,
  input  logic                freeze,
  input  logic                clear,
`ifdef PEAK_HOLD_EN
  input  logic                peak_clear,
  output logic [N*W-1:0]      peak_display,
`endif
  output logic [N*W-1:0]      ch_display,
  output logic                update,
  output logic [AVG_LOG2:0]   window_cnt
);

  localparam int AW = W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N-1:0][AW-1:0]  acc_q, acc_d;
  logic [N-1:0][AW-1:0]  sum;
  logic [N-1:0][W-1:0]   avg;
  logic [N-1:0][W-1:0]   disp_q, disp_d;
  logic                  upd_q, upd_d;
  logic                  take;
  logic                  complete;
  logic                  publish;

  // A sample is only taken when clear is low; clear drops any coincident sample.
  assign take     = sample_valid && !clear;
  assign complete = take && (cnt_q == LAST);
  assign publish  = complete && !freeze;

  // Running sum including the current sample, and its truncated window average.
  always_comb begin
    sum = '0;
    avg = '0;
    for (int k = 0; k < N; k++) begin
      sum[k] = acc_q[k] + AW'(ch_in[k*W +: W]);
      avg[k] = sum[k][AVG_LOG2 +: W];
    end
  end

  // Accumulator / window counter next state: clear wins, completion restarts the window.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_valid) begin
      if (complete) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Display registers load the average only on an unfrozen completing sample.
  always_comb begin
    disp_d = publish ? avg : disp_q;
    upd_d  = publish;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      upd_q  <= upd_d;
    end
  end

  assign ch_display = disp_q;
  assign update     = upd_q;
  assign window_cnt = cnt_q;

`ifdef PEAK_HOLD_EN
  logic [N-1:0][W-1:0] peak_q, peak_d;
  logic [N-1:0][W-1:0] peak_base;

  // Peak clear applies first, then a publish compares its average against what remains.
  always_comb begin
    peak_base = '0;
    peak_d    = '0;
    for (int k = 0; k < N; k++) begin
      peak_base[k] = peak_clear ? '0 : peak_q[k];
      peak_d[k]    = (publish && (avg[k] > peak_base[k])) ? avg[k] : peak_base[k];
    end
  end

  // Peak registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_display = peak_q;
`endif

endmodule

// File: tb/tb_display_avg_bank.sv
// Directed + scoreboard bench for display_avg_bank (AVG_LOG2=2 main instance, AVG_LOG2=0 side instance).
// Publishes are pushed to a queue by the stimulus model and popped by a negedge monitor.
// Inputs change at negedge; outputs are sampled on the negedge following each active edge.
module tb_display_avg_bank;

  localparam int N        = 5;
  localparam int W        = 12;
  localparam int AVG_LOG2 = 2;
  localparam int WIN      = 1 << AVG_LOG2;

  typedef struct {
    logic [N*W-1:0] disp;
    logic [N*W-1:0] peak;
    int             cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_valid;
  logic [N*W-1:0]     ch_in;
  logic               freeze;
  logic               clear;
  logic               peak_clear;
  logic [N*W-1:0]     ch_display;
  logic               update;
  logic [AVG_LOG2:0]  window_cnt;
  logic [N*W-1:0]     ch_display0;
  logic               update0;
  logic [0:0]         window_cnt0;
`ifdef PEAK_HOLD_EN
  logic [N*W-1:0]     peak_display;
  logic [N*W-1:0]     peak_display0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  exp_t sb[$];

  int             m_acc [N];
  int             m_cnt;
  int             m_peak [N];
  logic [N*W-1:0] m_disp;
  logic [N*W-1:0] m_peakv;
  logic [N*W-1:0] m_disp0;

  display_avg_bank #(.N(N), .W(W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .ch_in        (ch_in),
    .freeze       (freeze),
    .clear        (clear),
`ifdef PEAK_HOLD_EN
    .peak_clear   (peak_clear),
    .peak_display (peak_display),
`endif
    .ch_display   (ch_display),
    .update       (update),
    .window_cnt   (window_cnt)
  );

  display_avg_bank #(.N(N), .W(W), .AVG_LOG2(0)) dut0 (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .ch_in        (ch_in),
    .freeze       (freeze),
    .clear        (clear),
`ifdef PEAK_HOLD_EN
    .peak_clear   (peak_clear),
    .peak_display (peak_display0),
`endif
    .ch_display   (ch_display0),
    .update       (update0),
    .window_cnt   (window_cnt0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every update pulse must match the oldest queued publish.
  always @(negedge clk) begin
    if (!reset && update === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_update", 64'(update), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("update_cycle", 64'(cyc), 64'(e.cyc));
        check("ch_display", 64'(ch_display), 64'(e.disp));
`ifdef PEAK_HOLD_EN
        check("peak_display", 64'(peak_display), 64'(e.peak));
`endif
      end
    end
  end

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c, input int d, input int e);
    logic [N*W-1:0] r;
    r = '0;
    r[0*W +: W] = a[W-1:0];
    r[1*W +: W] = b[W-1:0];
    r[2*W +: W] = c[W-1:0];
    r[3*W +: W] = d[W-1:0];
    r[4*W +: W] = e[W-1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_acc[k]  = 0;
      m_peak[k] = 0;
    end
    m_cnt   = 0;
    m_disp  = '0;
    m_peakv = '0;
    m_disp0 = '0;
  endtask

  // One clock cycle of stimulus, model update and per-cycle checks.
  task automatic apply(input logic v, input logic [N*W-1:0] d,
                       input logic f = 1'b0, input logic c = 1'b0, input logic pc = 1'b0);
    int   avg [N];
    int   base;
    logic pub;
    logic exp_u0;
    exp_t e;
    sample_valid = v;
    ch_in        = d;
    freeze       = f;
    clear        = c;
    peak_clear   = pc;
    @(posedge clk);
    #1;
    pub    = 1'b0;
    exp_u0 = 1'b0;
    for (int k = 0; k < N; k++) avg[k] = 0;
    if (c) begin
      for (int k = 0; k < N; k++) m_acc[k] = 0;
      m_cnt = 0;
    end else if (v) begin
      if (m_cnt == WIN - 1) begin
        for (int k = 0; k < N; k++) begin
          avg[k]   = (m_acc[k] + int'(d[k*W +: W])) / WIN;
          m_acc[k] = 0;
        end
        m_cnt = 0;
        pub   = !f;
      end else begin
        for (int k = 0; k < N; k++) m_acc[k] += int'(d[k*W +: W]);
        m_cnt++;
      end
      if (!f) begin
        m_disp0 = d;
        exp_u0  = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      base = pc ? 0 : m_peak[k];
      m_peak[k] = (pub && avg[k] > base) ? avg[k] : base;
      m_peakv[k*W +: W] = m_peak[k][W-1:0];
    end
    if (pub) begin
      for (int k = 0; k < N; k++) m_disp[k*W +: W] = avg[k][W-1:0];
      e.disp = m_disp;
      e.peak = m_peakv;
      e.cyc  = cyc;
      sb.push_back(e);
    end
    sample_valid = 1'b0;
    freeze       = 1'b0;
    clear        = 1'b0;
    peak_clear   = 1'b0;
    @(negedge clk);
    check("window_cnt", 64'(window_cnt), 64'(m_cnt));
    check("dut0_update", 64'(update0), 64'(exp_u0));
    check("dut0_display", 64'(ch_display0), 64'(m_disp0));
    check("dut0_window_cnt", 64'(window_cnt0), 64'(0));
  endtask

  task automatic win(input logic [N*W-1:0] d, input logic f_last = 1'b0,
                     input logic c_last = 1'b0, input logic pc_last = 1'b0);
    for (int i = 0; i < WIN - 1; i++) apply(1'b1, d);
    apply(1'b1, d, f_last, c_last, pc_last);
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    ch_in        = '0;
    freeze       = 1'b0;
    clear        = 1'b0;
    peak_clear   = 1'b0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_ch_display", 64'(ch_display), 64'(0));
    check("rst_window_cnt", 64'(window_cnt), 64'(0));
    check("rst_update", 64'(update), 64'(0));
    reset = 1'b0;

    // Publish something, then reset asynchronously mid-window
    win(pk(7, 8, 9, 10, 11));
    check("pre_rst_ch0", 64'(ch_display[11:0]), 64'(7));
    apply(1'b1, pk(5, 5, 5, 5, 5));
    apply(1'b1, pk(5, 5, 5, 5, 5));
    check("mid_window_cnt", 64'(window_cnt), 64'(2));
    #2 reset = 1'b1;
    #1;
    check("async_rst_ch_display", 64'(ch_display), 64'(0));
    check("async_rst_window_cnt", 64'(window_cnt), 64'(0));
    check("async_rst_update", 64'(update), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    win(pk(100, 1, 2, 3, 4));
    check("post_rst_ch0", 64'(ch_display[11:0]), 64'(100));

    // Averaging with truncation and full-scale input
    apply(1'b1, pk(10, 4095, 0, 1000, 7));
    apply(1'b1, pk(11, 4095, 1, 2000, 0));
    apply(1'b1, pk(11, 4095, 2, 3000, 0));
    apply(1'b1, pk(11, 4095, 3, 4000, 0));
    check("trunc_ch0", 64'(ch_display[11:0]), 64'(10));
    check("fullscale_ch1", 64'(ch_display[23:12]), 64'(4095));
    check("ch3_avg", 64'(ch_display[47:36]), 64'(2500));

    // Gapped valid samples
    apply(1'b1, pk(20, 40, 60, 80, 100));
    apply(1'b0, pk(999, 999, 999, 999, 999));
    apply(1'b1, pk(24, 40, 60, 80, 100));
    apply(1'b0, '0);
    apply(1'b0, '0);
    apply(1'b1, pk(20, 40, 60, 80, 100));
    check("gap_no_early_update", 64'(update), 64'(0));
    apply(1'b0, '0);
    apply(1'b1, pk(20, 40, 60, 80, 103));
    check("gap_ch0", 64'(ch_display[11:0]), 64'(21));
    check("gap_ch4", 64'(ch_display[59:48]), 64'(100));

    // Freeze at completion holds the previous display
    win(pk(100, 100, 100, 100, 100));
    win(pk(200, 200, 200, 200, 200), 1'b1);
    check("freeze_hold_ch0", 64'(ch_display[11:0]), 64'(100));
    check("freeze_no_update", 64'(update), 64'(0));
    win(pk(300, 300, 300, 300, 300));
    check("unfreeze_ch0", 64'(ch_display[11:0]), 64'(300));

    // Clear colliding with the completing sample
    win(pk(77, 77, 77, 77, 77), 1'b0, 1'b1);
    check("clear_no_update", 64'(update), 64'(0));
    check("clear_keeps_display", 64'(ch_display[11:0]), 64'(300));
    win(pk(50, 50, 50, 50, 50));
    check("after_clear_ch0", 64'(ch_display[11:0]), 64'(50));

`ifdef PEAK_HOLD_EN
    // Peak hold
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("peak_cleared", 64'(peak_display), 64'(0));
    win(pk(100, 100, 100, 100, 100));
    win(pk(300, 300, 300, 300, 300));
    win(pk(200, 200, 200, 200, 200));
    check("peak_max_ch0", 64'(peak_display[11:0]), 64'(300));
    win(pk(150, 150, 150, 150, 150), 1'b0, 1'b0, 1'b1);
    check("peak_clear_publish_ch0", 64'(peak_display[11:0]), 64'(150));
`endif

    // Pseudo-random traffic against the model
    for (int i = 0; i < 60; i++) begin
      apply(($urandom % 4) != 0, {$urandom, $urandom},
            ($urandom % 5) == 0, ($urandom % 9) == 0, ($urandom % 7) == 0);
    end

    apply(1'b0, '0);
    apply(1'b0, '0);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
